// File: rtl/hit_penalty_controller_pkg.sv
// Shared frame-state, winner and FSM encodings for the hit penalty path.
// Shared with the collision checker so both sides agree on the codes.
package hit_penalty_controller_pkg;

    typedef enum logic [1:0] {
        FS_NOHIT     = 2'b00,
        FS_HITSTUN   = 2'b01,
        FS_BLOCKSTUN = 2'b10
    } frame_state_e;

    typedef enum logic [1:0] {
        WIN_NONE  = 2'b00,
        WIN_CHAR1 = 2'b01,
        WIN_CHAR2 = 2'b10,
        WIN_DRAW  = 2'b11
    } winner_e;

    typedef enum logic {
        ST_PLAY = 1'b0,
        ST_OVER = 1'b1
    } state_e;

    localparam int STUN_W = 8;

    // Code 11 carries no stun, so only the two real stun codes start an event.
    function automatic logic is_stun_code(input logic [1:0] fs);
        return (fs == FS_HITSTUN) || (fs == FS_BLOCKSTUN);
    endfunction

endpackage

// File: rtl/hit_penalty_controller_if.sv
// Bundle between collision checker / game logic and the penalty controller.
// master drives frame codes and pulses; slave returns stun, health, result.
interface hit_penalty_controller_if #(
    parameter int HEALTH_W = 2
);
    logic                frame_tick;
    logic                new_round;
    logic [1:0]          char1_frame_state;
    logic [1:0]          char2_frame_state;
    logic                char1_stun;
    logic                char1_blockstun;
    logic                char2_stun;
    logic                char2_blockstun;
    logic [HEALTH_W-1:0] char1_health;
    logic [HEALTH_W-1:0] char2_health;
    logic                game_over;
    logic [1:0]          winner;

    modport master (
        output frame_tick, new_round,
        output char1_frame_state, char2_frame_state,
        input  char1_stun, char1_blockstun,
        input  char2_stun, char2_blockstun,
        input  char1_health, char2_health,
        input  game_over, winner
    );

    modport slave (
        input  frame_tick, new_round,
        input  char1_frame_state, char2_frame_state,
        output char1_stun, char1_blockstun,
        output char2_stun, char2_blockstun,
        output char1_health, char2_health,
        output game_over, winner
    );
endinterface

// File: rtl/hit_penalty_controller_stun_timer.sv
// Per-character stun down-counter in video frames.
// A load wins over a coincident frame tick; kind clears when count hits 0.
import hit_penalty_controller_pkg::*;

module stun_timer (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [STUN_W-1:0] load_value,
    input  logic              load_kind,
    input  logic              frame_tick,
    output logic              stun,
    output logic              blockstun
);
    logic [STUN_W-1:0] count_q;
    logic              kind_q;

    // Count register: clear, then load, then tick-driven decrement.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count_q <= '0;
            kind_q  <= 1'b0;
        end else if (load) begin
            count_q <= load_value;
            kind_q  <= load_kind;
        end else if (frame_tick && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
            if (count_q == STUN_W'(1))
                kind_q <= 1'b0;
        end
    end

    assign stun      = (count_q != '0);
    assign blockstun = kind_q;
endmodule

// File: rtl/hit_penalty_controller.sv
// Turns collision frame-state codes into stun, health and round result.
// Optional macro BLOCK_CHIP_DAMAGE_EN: blocked hits also remove 1 health.
import hit_penalty_controller_pkg::*;

module hit_penalty_controller #(
    parameter int HEALTH_MAX       = 3,
    parameter int HEALTH_W         = 2,
    parameter int HITSTUN_FRAMES   = 16,
    parameter int BLOCKSTUN_FRAMES = 8,
    parameter int HIT_DAMAGE       = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    hit_penalty_controller_if.slave bus
);
    typedef logic [HEALTH_W-1:0] health_t;

    state_e     state_q, state_d;
    logic [1:0] winner_q, winner_d;
    logic [1:0] prev1_q, prev2_q;
    health_t    health1_q, health2_q;
    logic       stun1, stun2;
    logic       bstun1, bstun2;
    logic       ko, live, clear;
    logic       acc1, acc2, hit1, hit2;

    function automatic health_t next_health(
        input health_t h,
        input logic    hit,
        input logic    blk
    );
        health_t d;
        d = '0;
        if (hit)
            d = health_t'(HIT_DAMAGE);
`ifdef BLOCK_CHIP_DAMAGE_EN
        else if (blk)
            d = health_t'(1);
`else
        else if (blk)
            d = '0;
`endif
        return (h > d) ? health_t'(h - d) : '0;
    endfunction

    // Once a health reaches 0 the round is decided; no further events count.
    assign ko    = (health1_q == '0) || (health2_q == '0);
    assign live  = (state_q == ST_PLAY) && !ko && !bus.new_round;
    assign clear = bus.new_round || (state_q == ST_OVER) || ko;

    assign acc1 = live && !stun1 && is_stun_code(bus.char1_frame_state)
                  && !is_stun_code(prev1_q);
    assign acc2 = live && !stun2 && is_stun_code(bus.char2_frame_state)
                  && !is_stun_code(prev2_q);
    assign hit1 = acc1 && (bus.char1_frame_state == FS_HITSTUN);
    assign hit2 = acc2 && (bus.char2_frame_state == FS_HITSTUN);

    // Previous frame codes for edge-style event detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev1_q <= FS_NOHIT;
            prev2_q <= FS_NOHIT;
        end else begin
            prev1_q <= bus.char1_frame_state;
            prev2_q <= bus.char2_frame_state;
        end
    end

    // Health: refilled on reset or new round, reduced by accepted events.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.new_round) begin
            health1_q <= health_t'(HEALTH_MAX);
            health2_q <= health_t'(HEALTH_MAX);
        end else begin
            health1_q <= next_health(health1_q, hit1, acc1 && !hit1);
            health2_q <= next_health(health2_q, hit2, acc2 && !hit2);
        end
    end

    // Round FSM state and winner registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_PLAY;
            winner_q <= WIN_NONE;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
        end
    end

    // Next state: new_round restarts, a zero health ends play.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        if (bus.new_round) begin
            state_d  = ST_PLAY;
            winner_d = WIN_NONE;
        end else if ((state_q == ST_PLAY) && ko) begin
            state_d  = ST_OVER;
            winner_d = {health1_q == '0, health2_q == '0};
        end
    end

    stun_timer u_stun1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .load       (acc1),
        .load_value (hit1 ? STUN_W'(HITSTUN_FRAMES)
                          : STUN_W'(BLOCKSTUN_FRAMES)),
        .load_kind  (!hit1),
        .frame_tick (bus.frame_tick),
        .stun       (stun1),
        .blockstun  (bstun1)
    );

    stun_timer u_stun2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .load       (acc2),
        .load_value (hit2 ? STUN_W'(HITSTUN_FRAMES)
                          : STUN_W'(BLOCKSTUN_FRAMES)),
        .load_kind  (!hit2),
        .frame_tick (bus.frame_tick),
        .stun       (stun2),
        .blockstun  (bstun2)
    );

    assign bus.char1_stun      = stun1;
    assign bus.char1_blockstun = bstun1;
    assign bus.char2_stun      = stun2;
    assign bus.char2_blockstun = bstun2;
    assign bus.char1_health    = health1_q;
    assign bus.char2_health    = health2_q;
    assign bus.game_over       = (state_q == ST_OVER);
    assign bus.winner          = winner_q;
endmodule

// File: tb/tb_hit_penalty_controller.sv
// Directed bench for hit_penalty_controller (HITSTUN=4, BLOCKSTUN=2).
// Block health expectation follows BLOCK_CHIP_DAMAGE_EN.
module tb_hit_penalty_controller;

    logic clk;
    logic rst_n;
    int   total;
    int   fails;
    int   exp_h1;

    hit_penalty_controller_if #(.HEALTH_W(2)) bus ();

    hit_penalty_controller #(
        .HEALTH_MAX       (3),
        .HEALTH_W         (2),
        .HITSTUN_FRAMES   (4),
        .BLOCKSTUN_FRAMES (2),
        .HIT_DAMAGE       (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            cyc();
        end
        bus.frame_tick = 1'b0;
    endtask

    initial begin
        total = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.frame_tick = 1'b0;
        bus.new_round = 1'b0;
        bus.char1_frame_state = 2'b00;
        bus.char2_frame_state = 2'b00;
        cyc();
        cyc();
        chk("rst_stun1", bus.char1_stun, 1'b0);
        chk("rst_stun2", bus.char2_stun, 1'b0);
        chk("rst_h1", bus.char1_health, 2'd3);
        chk("rst_h2", bus.char2_health, 2'd3);
        chk("rst_go", bus.game_over, 1'b0);
        chk("rst_win", bus.winner, 2'b00);
        rst_n = 1'b1;
        cyc();

        // 1: held hit counts once, stun lasts 4 ticks
        bus.char2_frame_state = 2'b01;
        cyc();
        chk("t1_h2", bus.char2_health, 2'd2);
        chk("t1_stun", bus.char2_stun, 1'b1);
        chk("t1_bs", bus.char2_blockstun, 1'b0);
        for (int i = 0; i < 49; i++) begin
            bus.frame_tick = (i % 16 == 5);
            cyc();
        end
        bus.frame_tick = 1'b0;
        chk("t1_h2_held", bus.char2_health, 2'd2);
        chk("t1_stun_3tk", bus.char2_stun, 1'b1);
        bus.char2_frame_state = 2'b00;
        ticks(1);
        chk("t1_stun_4tk", bus.char2_stun, 1'b0);

        // 2: block on char1
        exp_h1 = 3;
`ifdef BLOCK_CHIP_DAMAGE_EN
        exp_h1 = 2;
`endif
        bus.char1_frame_state = 2'b10;
        cyc();
        bus.char1_frame_state = 2'b00;
        chk("t2_stun", bus.char1_stun, 1'b1);
        chk("t2_bs", bus.char1_blockstun, 1'b1);
        chk("t2_h1", bus.char1_health, exp_h1);
        ticks(1);
        chk("t2_stun_1tk", bus.char1_stun, 1'b1);
        chk("t2_bs_1tk", bus.char1_blockstun, 1'b1);
        ticks(1);
        chk("t2_stun_2tk", bus.char1_stun, 1'b0);
        chk("t2_bs_2tk", bus.char1_blockstun, 1'b0);

        // 3: event during stun is dropped, no reload
        bus.char2_frame_state = 2'b01;
        cyc();
        chk("t3_h2", bus.char2_health, 2'd1);
        bus.char2_frame_state = 2'b00;
        ticks(1);
        bus.char2_frame_state = 2'b01;
        cyc();
        bus.char2_frame_state = 2'b00;
        chk("t3_h2_drop", bus.char2_health, 2'd1);
        ticks(2);
        chk("t3_stun_3tk", bus.char2_stun, 1'b1);
        ticks(1);
        chk("t3_stun_4tk", bus.char2_stun, 1'b0);

        // 4: knockout of char2
        bus.char2_frame_state = 2'b01;
        cyc();
        bus.char2_frame_state = 2'b00;
        chk("t4_h2", bus.char2_health, 2'd0);
        chk("t4_go_early", bus.game_over, 1'b0);
        cyc();
        chk("t4_go", bus.game_over, 1'b1);
        chk("t4_win", bus.winner, 2'b01);
        chk("t4_stun2", bus.char2_stun, 1'b0);
        bus.char1_frame_state = 2'b01;
        cyc();
        bus.char1_frame_state = 2'b00;
        cyc();
        chk("t4_h1_ign", bus.char1_health, exp_h1);
        chk("t4_stun1_ign", bus.char1_stun, 1'b0);
        chk("t4_go_hold", bus.game_over, 1'b1);
        bus.new_round = 1'b1;
        cyc();
        bus.new_round = 1'b0;
        chk("t4_nr_h1", bus.char1_health, 2'd3);
        chk("t4_nr_h2", bus.char2_health, 2'd3);
        chk("t4_nr_go", bus.game_over, 1'b0);
        chk("t4_nr_win", bus.winner, 2'b00);

        // 5: draw
        for (int k = 0; k < 2; k++) begin
            bus.char1_frame_state = 2'b01;
            bus.char2_frame_state = 2'b01;
            cyc();
            bus.char1_frame_state = 2'b00;
            bus.char2_frame_state = 2'b00;
            ticks(4);
        end
        chk("t5_h1", bus.char1_health, 2'd1);
        chk("t5_h2", bus.char2_health, 2'd1);
        bus.char1_frame_state = 2'b01;
        bus.char2_frame_state = 2'b01;
        cyc();
        bus.char1_frame_state = 2'b00;
        bus.char2_frame_state = 2'b00;
        chk("t5_h1_0", bus.char1_health, 2'd0);
        chk("t5_h2_0", bus.char2_health, 2'd0);
        cyc();
        chk("t5_go", bus.game_over, 1'b1);
        chk("t5_win", bus.winner, 2'b11);
        chk("t5_stun1", bus.char1_stun, 1'b0);
        bus.new_round = 1'b1;
        cyc();
        bus.new_round = 1'b0;

        // 6: reset mid-stun with held hit code
        bus.char1_frame_state = 2'b01;
        cyc();
        bus.char1_frame_state = 2'b00;
        ticks(4);
        bus.char1_frame_state = 2'b01;
        cyc();
        chk("t6_h1_pre", bus.char1_health, 2'd1);
        chk("t6_stun_pre", bus.char1_stun, 1'b1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("t6_rst_stun", bus.char1_stun, 1'b0);
        chk("t6_rst_h1", bus.char1_health, 2'd3);
        cyc();
        chk("t6_fresh_h1", bus.char1_health, 2'd2);
        chk("t6_fresh_stun", bus.char1_stun, 1'b1);
        bus.char1_frame_state = 2'b00;
        ticks(4);

        // 7: new_round discards coincident event
        bus.char2_frame_state = 2'b01;
        bus.new_round = 1'b1;
        cyc();
        bus.new_round = 1'b0;
        bus.char2_frame_state = 2'b00;
        chk("t7_h2", bus.char2_health, 2'd3);
        chk("t7_stun2", bus.char2_stun, 1'b0);
        chk("t7_h1", bus.char1_health, 2'd3);

        // 8: code 11 acts as NOHIT for the previous state
        bus.char2_frame_state = 2'b11;
        cyc();
        chk("t8_h2_11", bus.char2_health, 2'd3);
        bus.char2_frame_state = 2'b01;
        cyc();
        bus.char2_frame_state = 2'b00;
        chk("t8_h2", bus.char2_health, 2'd2);
        chk("t8_stun2", bus.char2_stun, 1'b1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
